// File: rtl/ace_instbuf.sv
// Instruction buffer between fetch and decode: compacts up to 8 valid fetch slots per cycle
// into a circular queue and presents the oldest 4 entries to decode, first-word-fall-through.
module ace_instbuf #(
  parameter int DEPTH = 16,
  parameter int IW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          retire_flush_i,
  input  logic [IW-1:0] fetch_inst0_i,
  input  logic [IW-1:0] fetch_inst1_i,
  input  logic [IW-1:0] fetch_inst2_i,
  input  logic [IW-1:0] fetch_inst3_i,
  input  logic [IW-1:0] fetch_inst4_i,
  input  logic [IW-1:0] fetch_inst5_i,
  input  logic [IW-1:0] fetch_inst6_i,
  input  logic [IW-1:0] fetch_inst7_i,
  input  logic          fetch_inst0_vld_i,
  input  logic          fetch_inst1_vld_i,
  input  logic          fetch_inst2_vld_i,
  input  logic          fetch_inst3_vld_i,
  input  logic          fetch_inst4_vld_i,
  input  logic          fetch_inst5_vld_i,
  input  logic          fetch_inst6_vld_i,
  input  logic          fetch_inst7_vld_i,
  input  logic [2:0]    deq_cnt_i,
  output logic [IW-1:0] inst0_o,
  output logic [IW-1:0] inst1_o,
  output logic [IW-1:0] inst2_o,
  output logic [IW-1:0] inst3_o,
  output logic          inst0_vld_o,
  output logic          inst1_vld_o,
  output logic          inst2_vld_o,
  output logic          inst3_vld_o,
  output logic          instbuf_full_o,
  output logic          instbuf_empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Full leaves room for a whole 8-slot group, so an accepted group can never overflow.
  localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - 8);

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [IW-1:0] fetch_inst [8];
  logic [7:0]    fetch_vld;
  logic [AW-1:0] wr_idx [8];
  logic [3:0]    n_wr;
  logic [CW-1:0] n_rd;
  logic          wr_en;
  logic [IW-1:0] lane_inst [4];
  logic [3:0]    lane_vld;

  function automatic logic [CW-1:0] clamp_rd(input logic [2:0] req, input logic [CW-1:0] avail);
    logic [CW-1:0] r;
    r = (req > 3'd4) ? CW'(3'd4) : CW'(req);
    return (r > avail) ? avail : r;
  endfunction

  always_comb begin
    fetch_inst[0] = fetch_inst0_i;
    fetch_inst[1] = fetch_inst1_i;
    fetch_inst[2] = fetch_inst2_i;
    fetch_inst[3] = fetch_inst3_i;
    fetch_inst[4] = fetch_inst4_i;
    fetch_inst[5] = fetch_inst5_i;
    fetch_inst[6] = fetch_inst6_i;
    fetch_inst[7] = fetch_inst7_i;
    fetch_vld = {fetch_inst7_vld_i, fetch_inst6_vld_i, fetch_inst5_vld_i, fetch_inst4_vld_i,
                 fetch_inst3_vld_i, fetch_inst2_vld_i, fetch_inst1_vld_i, fetch_inst0_vld_i};
  end

  assign instbuf_full_o  = (count_q > FULL_THR);
  assign instbuf_empty_o = (count_q == '0);
  assign wr_en           = !instbuf_full_o && !retire_flush_i;
  assign n_rd            = clamp_rd(deq_cnt_i, count_q);

  // n_wr doubles as the running prefix count, so each slot lands just after the previous valid one.
  always_comb begin
    n_wr = 4'd0;
    for (int k = 0; k < 8; k++) begin
      wr_idx[k] = tail_q + AW'(n_wr);
      n_wr      = n_wr + {3'b000, fetch_vld[k]};
    end
  end

  always_comb begin
    head_d  = head_q + n_rd[AW-1:0];
    tail_d  = tail_q + (wr_en ? AW'(n_wr) : '0);
    count_d = count_q + (wr_en ? CW'(n_wr) : '0) - n_rd;
    if (retire_flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (wr_en && fetch_vld[k]) mem_q[wr_idx[k]] <= fetch_inst[k];
    end
  end

  // Output lanes are driven only from registered state; stale storage is masked to zero.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_vld[k]  = (count_q > CW'(k));
      lane_inst[k] = lane_vld[k] ? mem_q[head_q + AW'(k)] : '0;
    end
  end

  assign inst0_o     = lane_inst[0];
  assign inst1_o     = lane_inst[1];
  assign inst2_o     = lane_inst[2];
  assign inst3_o     = lane_inst[3];
  assign inst0_vld_o = lane_vld[0];
  assign inst1_vld_o = lane_vld[1];
  assign inst2_vld_o = lane_vld[2];
  assign inst3_vld_o = lane_vld[3];

endmodule

// File: tb/tb_ace_instbuf.sv
// Directed and random stimulus for ace_instbuf, checked against a queue-based reference model.
module tb_ace_instbuf;
  localparam int DEPTH = 16;
  localparam int IW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          retire_flush_i;
  logic [IW-1:0] fi [8];
  logic [7:0]    fv;
  logic [2:0]    deq_cnt_i;
  logic [IW-1:0] inst_o [4];
  logic [3:0]    vld_o;
  logic          full_o, empty_o;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] model_q [$];
  int unsigned   mhead = 0;
  logic [IW-1:0] next_data = 32'h1000;

  ace_instbuf #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clock(clock), .reset(reset), .retire_flush_i(retire_flush_i),
    .fetch_inst0_i(fi[0]), .fetch_inst1_i(fi[1]), .fetch_inst2_i(fi[2]), .fetch_inst3_i(fi[3]),
    .fetch_inst4_i(fi[4]), .fetch_inst5_i(fi[5]), .fetch_inst6_i(fi[6]), .fetch_inst7_i(fi[7]),
    .fetch_inst0_vld_i(fv[0]), .fetch_inst1_vld_i(fv[1]), .fetch_inst2_vld_i(fv[2]),
    .fetch_inst3_vld_i(fv[3]), .fetch_inst4_vld_i(fv[4]), .fetch_inst5_vld_i(fv[5]),
    .fetch_inst6_vld_i(fv[6]), .fetch_inst7_vld_i(fv[7]),
    .deq_cnt_i(deq_cnt_i),
    .inst0_o(inst_o[0]), .inst1_o(inst_o[1]), .inst2_o(inst_o[2]), .inst3_o(inst_o[3]),
    .inst0_vld_o(vld_o[0]), .inst1_vld_o(vld_o[1]), .inst2_vld_o(vld_o[2]), .inst3_vld_o(vld_o[3]),
    .instbuf_full_o(full_o), .instbuf_empty_o(empty_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vld%0d", k), {31'd0, vld_o[k]}, {31'd0, (n > k)});
      chk($sformatf("inst%0d", k), inst_o[k], (n > k) ? model_q[k] : '0);
    end
    chk("empty", {31'd0, empty_o}, {31'd0, (n == 0)});
    chk("full", {31'd0, full_o}, {31'd0, (n > DEPTH - 8)});
    chk("count", 32'(dut.count_q), 32'(n));
    chk("head", 32'(dut.head_q), 32'(mhead));
  endtask

  // One clock: drive inputs, advance the model with the pre-edge state, compare after the edge.
  task automatic step(input logic [7:0] v, input logic [IW-1:0] base, input logic [2:0] deq,
                      input logic flush);
    int nrd;
    bit accept;
    for (int k = 0; k < 8; k++) fi[k] = base + IW'(k);
    fv = v;
    deq_cnt_i = deq;
    retire_flush_i = flush;
    accept = !(model_q.size() > DEPTH - 8) && !flush;
    nrd = (deq > 4) ? 4 : int'(deq);
    if (nrd > model_q.size()) nrd = model_q.size();
    @(posedge clock);
    #1;
    if (flush) begin
      model_q.delete();
      mhead = 0;
    end else begin
      for (int i = 0; i < nrd; i++) void'(model_q.pop_front());
      mhead = (mhead + nrd) % DEPTH;
      if (accept) for (int k = 0; k < 8; k++) if (v[k]) model_q.push_back(base + IW'(k));
    end
    check_all();
  endtask

  task automatic step_seq(input logic [7:0] v, input logic [2:0] deq);
    step(v, next_data, deq, 1'b0);
    next_data = next_data + 32'h10;
  endtask

  initial begin
    reset = 1'b1;
    retire_flush_i = 1'b0;
    fv = '0;
    deq_cnt_i = '0;
    for (int k = 0; k < 8; k++) fi[k] = '0;
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;

    // basic fill of four lanes
    step(8'b0000_1111, 32'h11, 3'd0, 1'b0);
    step(8'h00, 32'h0, 3'd4, 1'b0);

    // non-contiguous compaction
    step(8'b1010_0101, 32'hA0, 3'd0, 1'b0);
    step(8'h00, 32'h0, 3'd4, 1'b0);

    // full threshold and dropped group
    step_seq(8'hFF, 3'd0);
    step_seq(8'h01, 3'd0);
    step_seq(8'hFF, 3'd0);
    step_seq(8'h00, 3'd1);
    step_seq(8'h00, 3'd4);
    step_seq(8'h00, 3'd4);

    // steer head and tail to 12
    step_seq(8'hFF, 3'd0);
    step_seq(8'h07, 3'd4);
    step_seq(8'h00, 3'd4);
    step_seq(8'h00, 3'd3);

    // wrap-around with simultaneous read and write
    for (int i = 0; i < 8; i++) step_seq(8'hFF, 3'd4);
    for (int i = 0; i < 4; i++) step_seq(8'h00, 3'd4);

    // flush beats enqueue and dequeue
    step_seq(8'h3F, 3'd0);
    step_seq(8'hFF, 3'd4);
    step(8'hFF, 32'hF0, 3'd4, 1'b1);
    step(8'h01, 32'h55, 3'd0, 1'b0);

    // dequeue request above count is clamped
    step_seq(8'h01, 3'd0);
    step_seq(8'h00, 3'd7);

    // random patterns, including oversized dequeue requests
    for (int i = 0; i < 40; i++)
      step_seq(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    step_seq(8'h00, 3'd4);
    step(8'hFF, 32'hC0, 3'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
